// File: rtl/cpu_trace_printer.sv
// cpu_trace_printer: serializes one CPU write-back record into an ASCII trace
// line of the form ^<time>@<pc>: $<grf> <= <data># or ^<time>@<pc>: *<addr> <= <data>#,
// one character per accepted handshake on the char/char_valid/char_ready port.
module cpu_trace_printer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_type,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_grf,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  char,
    output logic        char_valid,
    input  logic        char_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_EMIT
    } state_t;

    // Field currently on the char output; multi-digit fields walk cnt down to 0.
    typedef enum logic [3:0] {
        G_CARET, G_TIME, G_AT, G_PC, G_COLON, G_SP1, G_MARK, G_GRF,
        G_ADDR, G_SP2, G_LT, G_EQ, G_SP3, G_DATA, G_HASH
    } seg_t;

    localparam logic [7:0] CH_CARET = "^";
    localparam logic [7:0] CH_AT    = "@";
    localparam logic [7:0] CH_COLON = ":";
    localparam logic [7:0] CH_SPACE = " ";
    localparam logic [7:0] CH_DOLL  = "$";
    localparam logic [7:0] CH_STAR  = "*";
    localparam logic [7:0] CH_LT    = "<";
    localparam logic [7:0] CH_EQ    = "=";
    localparam logic [7:0] CH_HASH  = "#";

    state_t      state, state_nxt;
    seg_t        seg, seg_nxt, seg_adv;
    logic [2:0]  cnt, cnt_nxt, cnt_adv;
    logic [3:0]  iter, iter_nxt;
    logic [7:0]  char_nxt, adv_char;
    logic        valid_nxt, ready_nxt;
    logic        load, step;

    logic        type_q;
    logic [31:0] pc_q, addr_q, data_q;
    logic [4:0]  grf_q;
    logic [29:0] dd;
    logic [13:0] time_sat;
    logic [15:0] bcd, bcd_sh;
    logic [2:0]  t_start, g_start;
    logic [1:0]  grf_tens;
    logic [3:0]  grf_ones;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [29:0] a;
        a = v;
        for (int k = 0; k < 4; k++) begin
            if (a[14 + 4*k +: 4] >= 4'd5)
                a[14 + 4*k +: 4] = a[14 + 4*k +: 4] + 4'd3;
        end
        return {a[28:0], 1'b0};
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic [3:0] nibble32(input logic [31:0] w, input logic [2:0] i);
        logic [31:0] s;
        s = w >> {i, 2'b00};
        return s[3:0];
    endfunction

    assign time_sat = (in_time > 14'd9999) ? 14'd9999 : in_time;
    assign bcd      = dd[29:14];

    // Leading-zero suppression: first digit position to print for time and grf.
    always_comb begin
        if (bcd[15:12] != 4'd0)      t_start = 3'd3;
        else if (bcd[11:8] != 4'd0)  t_start = 3'd2;
        else if (bcd[7:4] != 4'd0)   t_start = 3'd1;
        else                         t_start = 3'd0;

        if (grf_q >= 5'd30) begin
            grf_tens = 2'd3; grf_ones = 4'(grf_q - 5'd30);
        end else if (grf_q >= 5'd20) begin
            grf_tens = 2'd2; grf_ones = 4'(grf_q - 5'd20);
        end else if (grf_q >= 5'd10) begin
            grf_tens = 2'd1; grf_ones = 4'(grf_q - 5'd10);
        end else begin
            grf_tens = 2'd0; grf_ones = grf_q[3:0];
        end
        g_start = (grf_q >= 5'd10) ? 3'd1 : 3'd0;
    end

    // Position that follows the current one in the line.
    always_comb begin
        seg_adv = seg;
        cnt_adv = cnt - 3'd1;
        if (!((seg == G_TIME || seg == G_PC || seg == G_GRF || seg == G_ADDR ||
               seg == G_DATA) && cnt != 3'd0)) begin
            cnt_adv = 3'd0;
            case (seg)
                G_CARET: begin seg_adv = G_TIME; cnt_adv = t_start; end
                G_TIME:  seg_adv = G_AT;
                G_AT:    begin seg_adv = G_PC; cnt_adv = 3'd7; end
                G_PC:    seg_adv = G_COLON;
                G_COLON: seg_adv = G_SP1;
                G_SP1:   seg_adv = G_MARK;
                G_MARK: begin
                    if (type_q) begin seg_adv = G_ADDR; cnt_adv = 3'd7; end
                    else        begin seg_adv = G_GRF;  cnt_adv = g_start; end
                end
                G_GRF:   seg_adv = G_SP2;
                G_ADDR:  seg_adv = G_SP2;
                G_SP2:   seg_adv = G_LT;
                G_LT:    seg_adv = G_EQ;
                G_EQ:    seg_adv = G_SP3;
                G_SP3:   begin seg_adv = G_DATA; cnt_adv = 3'd7; end
                default: seg_adv = G_HASH;
            endcase
        end
    end

    // ASCII glyph for the following position.
    always_comb begin
        adv_char = CH_HASH;
        bcd_sh   = bcd >> {cnt_adv[1:0], 2'b00};
        case (seg_adv)
            G_CARET: adv_char = CH_CARET;
            G_TIME:  adv_char = 8'h30 + {4'h0, bcd_sh[3:0]};
            G_AT:    adv_char = CH_AT;
            G_PC:    adv_char = hex_ascii(nibble32(pc_q, cnt_adv));
            G_COLON: adv_char = CH_COLON;
            G_SP1:   adv_char = CH_SPACE;
            G_MARK:  adv_char = type_q ? CH_STAR : CH_DOLL;
            G_GRF:   adv_char = 8'h30 + (cnt_adv[0] ? {6'd0, grf_tens} : {4'd0, grf_ones});
            G_ADDR:  adv_char = hex_ascii(nibble32(addr_q, cnt_adv));
            G_SP2:   adv_char = CH_SPACE;
            G_LT:    adv_char = CH_LT;
            G_EQ:    adv_char = CH_EQ;
            G_SP3:   adv_char = CH_SPACE;
            G_DATA:  adv_char = hex_ascii(nibble32(data_q, cnt_adv));
            default: adv_char = CH_HASH;
        endcase
    end

    // Next-state and next registered-output logic.
    always_comb begin
        state_nxt = state;
        seg_nxt   = seg;
        cnt_nxt   = cnt;
        iter_nxt  = iter;
        char_nxt  = char;
        valid_nxt = char_valid;
        ready_nxt = in_ready;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_nxt = 1'b1;
                valid_nxt = 1'b0;
                char_nxt  = 8'h00;
                if (in_valid && in_ready) begin
                    state_nxt = ST_CONV;
                    ready_nxt = 1'b0;
                    iter_nxt  = 4'd0;
                    load      = 1'b1;
                end
            end
            ST_CONV: begin
                if (iter == 4'd14) begin
                    state_nxt = ST_EMIT;
                    seg_nxt   = G_CARET;
                    cnt_nxt   = 3'd0;
                    char_nxt  = CH_CARET;
                    valid_nxt = 1'b1;
                end else begin
                    step     = 1'b1;
                    iter_nxt = iter + 4'd1;
                end
            end
            ST_EMIT: begin
                if (char_ready) begin
                    if (seg == G_HASH) begin
                        state_nxt = ST_IDLE;
                        valid_nxt = 1'b0;
                        char_nxt  = 8'h00;
                        ready_nxt = 1'b1;
                    end else begin
                        seg_nxt  = seg_adv;
                        cnt_nxt  = cnt_adv;
                        char_nxt = adv_char;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                valid_nxt = 1'b0;
                char_nxt  = 8'h00;
            end
        endcase
    end

    // State, sequencer position and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            seg        <= G_CARET;
            cnt        <= 3'd0;
            iter       <= 4'd0;
            char       <= 8'h00;
            char_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            state      <= state_nxt;
            seg        <= seg_nxt;
            cnt        <= cnt_nxt;
            iter       <= iter_nxt;
            char       <= char_nxt;
            char_valid <= valid_nxt;
            in_ready   <= ready_nxt;
        end
    end

    // Record latch on accept and the binary-to-BCD shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q <= 1'b0;
            pc_q   <= 32'd0;
            grf_q  <= 5'd0;
            addr_q <= 32'd0;
            data_q <= 32'd0;
            dd     <= 30'd0;
        end else if (load) begin
            type_q <= in_type;
            pc_q   <= in_pc;
            grf_q  <= in_grf;
            addr_q <= in_addr;
            data_q <= in_data;
            dd     <= {16'd0, time_sat};
        end else if (step) begin
            dd     <= dd_step(dd);
        end
    end

endmodule

// File: tb/tb_cpu_trace_printer.sv
// Bench for cpu_trace_printer: expected characters are queued when a record is
// offered and popped by a monitor on every char handshake.
module tb_cpu_trace_printer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_type = 1'b0;
    logic [13:0] in_time = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_grf = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic [7:0]  char;
    logic        char_valid;
    logic        char_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    byte unsigned exp_q[$];

    always #5 clk = ~clk;

    cpu_trace_printer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_time    (in_time),
        .in_pc      (in_pc),
        .in_grf     (in_grf),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .char       (char),
        .char_valid (char_valid),
        .char_ready (char_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference line built independently of the DUT's field sequencer.
    function automatic string model_line(input logic t, input logic [13:0] tm, input logic [31:0] pc,
                                         input logic [4:0] g, input logic [31:0] a, input logic [31:0] d);
        int ts;
        ts = (tm > 14'd9999) ? 9999 : int'(tm);
        if (t) return $sformatf("^%0d@%08h: *%08h <= %08h#", ts, pc, a, d);
        return $sformatf("^%0d@%08h: $%0d <= %08h#", ts, pc, g, d);
    endfunction

    // Scoreboard pop on every handshake that the next rising edge will take.
    always @(negedge clk) begin
        if (!reset && char_valid && char_ready) begin
            if (exp_q.size() == 0) check("extra_char", 32'(char), 32'h0);
            else check("char", 32'(char), 32'(exp_q.pop_front()));
        end
    end

    task automatic send(input string tag, input logic t, input logic [13:0] tm, input logic [31:0] pc,
                        input logic [4:0] g, input logic [31:0] a, input logic [31:0] d,
                        input string exp_line, input bit stall, input bit abort);
        bit acc;
        bit stalled;
        int c;
        int n;
        n = exp_line.len();
        for (int i = 0; i < n; i++) exp_q.push_back(exp_line.getc(i));
        in_valid = 1'b1; in_type = t; in_time = tm; in_pc = pc; in_grf = g; in_addr = a; in_data = d;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk);
        end
        #1;
        check({tag, "_accept"}, 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_type = 1'($urandom_range(0, 1)); in_time = 14'($urandom); in_pc = $urandom;
        in_grf = 5'($urandom); in_addr = $urandom; in_data = $urandom;
        if (!acc) begin
            exp_q.delete();
            return;
        end
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        c = 0;
        while (c < 40 && !char_valid) begin
            @(posedge clk); #1; c++;
        end
        check({tag, "_latency"}, 32'(c), 32'd15);
        if (abort) begin
            repeat (9) begin @(posedge clk); #1; end
            check({tag, "_char10"}, 32'(char), 32'(exp_line.getc(9)));
            reset = 1'b1;
            #1;
            check({tag, "_rst_valid"}, 32'(char_valid), 32'd0);
            check({tag, "_rst_char"}, 32'(char), 32'd0);
            check({tag, "_rst_ready"}, 32'(in_ready), 32'd0);
            exp_q.delete();
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk); #1;
            check({tag, "_ready_after_rst"}, 32'(in_ready), 32'd1);
            return;
        end
        c = 0;
        stalled = 1'b0;
        while (c < 200 && !in_ready) begin
            if (stall && !stalled && char == "@") begin
                char_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1; c++;
                    check({tag, "_hold_char"}, 32'(char), 32'(8'h40));
                    check({tag, "_hold_valid"}, 32'(char_valid), 32'd1);
                end
                char_ready = 1'b1;
                stalled = 1'b1;
            end else begin
                @(posedge clk); #1; c++;
            end
        end
        check({tag, "_duration"}, 32'(c), 32'(n + (stall ? 3 : 0)));
        check({tag, "_end_valid"}, 32'(char_valid), 32'd0);
        check({tag, "_end_char"}, 32'(char), 32'd0);
        check({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        rt;
        logic [13:0] rtm;
        logic [31:0] rpc, ra, rd;
        logic [4:0]  rg;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(char_valid), 32'd0);
        check("rst_char", 32'(char), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_release", 32'(in_ready), 32'd1);

        send("mem", 1'b1, 14'd33, 32'h00003333, 5'd0, 32'h00003001, 32'hffffb528,
             "^33@00003333: *00003001 <= ffffb528#", 1'b0, 1'b0);
        send("reg0", 1'b0, 14'd0, 32'h00003000, 5'd0, 32'h0, 32'h0,
             "^0@00003000: $0 <= 00000000#", 1'b0, 1'b0);
        send("sat", 1'b0, 14'd12345, 32'h00400010, 5'd31, 32'h0, 32'hdeadbeef,
             "^9999@00400010: $31 <= deadbeef#", 1'b0, 1'b0);
        send("bp", 1'b0, 14'd77, 32'h0000300c, 5'd5, 32'h0, 32'h0000abcd,
             "^77@0000300c: $5 <= 0000abcd#", 1'b1, 1'b0);
        send("abort", 1'b1, 14'd33, 32'h00003333, 5'd0, 32'h00003001, 32'hffffb528,
             "^33@00003333: *00003001 <= ffffb528#", 1'b0, 1'b1);
        send("post_rst", 1'b1, 14'd456, 32'h00003010, 5'd0, 32'h0000a0f4, 32'h01234567,
             "^456@00003010: *0000a0f4 <= 01234567#", 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rt  = 1'($urandom_range(0, 1));
            rtm = 14'($urandom);
            rpc = $urandom; ra = $urandom; rd = $urandom;
            rg  = 5'($urandom);
            send("rand", rt, rtm, rpc, rg, ra, rd, model_line(rt, rtm, rpc, rg, ra, rd), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
